// File: rtl/pu_select.sv
// Conditional-select PU: loads cond, a, b over the shared bus and returns cond ? a : b on read.
// Outputs are zero when not enabled so several PUs can be OR-combined on one bus.
module pu_select #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATTR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StGotC, StGotA, StDone} state_e;

  state_e                state_q, state_d;
  logic                  cond_q, cond_d;
  // Only the invalid bit of the condition's attributes affects the result.
  logic                  cond_inv_q, cond_inv_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [ATTR_WIDTH-1:0] a_attr_q, a_attr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [ATTR_WIDTH-1:0] result_attr_q, result_attr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cond_q        <= 1'b0;
      cond_inv_q    <= 1'b0;
      a_q           <= '0;
      a_attr_q      <= '0;
      result_q      <= '0;
      result_attr_q <= '0;
    end else begin
      state_q       <= state_d;
      cond_q        <= cond_d;
      cond_inv_q    <= cond_inv_d;
      a_q           <= a_d;
      a_attr_q      <= a_attr_d;
      result_q      <= result_d;
      result_attr_q <= result_attr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cond_d        = cond_q;
    cond_inv_d    = cond_inv_q;
    a_d           = a_q;
    a_attr_d      = a_attr_q;
    result_d      = result_q;
    result_attr_d = result_attr_q;
    case (state_q)
      StIdle, StDone: begin
        if (wr) begin
          cond_d     = |data_in;
          cond_inv_d = attr_in[0];
          state_d    = StGotC;
        end else if (state_q == StDone && oe) begin
          // One-shot read: the result is consumed by the read.
          state_d = StIdle;
        end
      end
      StGotC: begin
        if (wr) begin
          a_d      = data_in;
          a_attr_d = attr_in;
          state_d  = StGotA;
        end
      end
      StGotA: begin
        if (wr) begin
          result_d         = cond_q ? a_q : data_in;
          result_attr_d    = cond_q ? a_attr_q : attr_in;
          result_attr_d[0] = result_attr_d[0] | cond_inv_q;
          state_d          = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_out = '0;
    attr_out = '0;
    if (oe) begin
      if (state_q == StDone) begin
        data_out = result_q;
        attr_out = result_attr_q;
      end else begin
        attr_out = {{(ATTR_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy = (state_q == StGotC) || (state_q == StGotA);

endmodule

// File: tb/tb_pu_select.sv
// Bench for pu_select: directed scenarios with literal expectations plus random traffic
// compared every cycle against an operand-queue model of the select unit.
module tb_pu_select;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr = 1'b0;
  logic          oe = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] attr_in = '0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] attr_out;
  logic          busy;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  pu_select #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .oe       (oe),
    .data_in  (data_in),
    .attr_in  (attr_in),
    .data_out (data_out),
    .attr_out (attr_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Model: operands collected in a queue; the third one triggers the select.
  logic [DW-1:0] op_data[$];
  logic [AW-1:0] op_attr[$];
  bit            res_valid = 0;
  logic [DW-1:0] res_data = '0;
  logic [AW-1:0] res_attr = '0;

  always @(posedge clk) begin
    if (rst) begin
      op_data.delete();
      op_attr.delete();
      res_valid = 0;
      res_data  = '0;
      res_attr  = '0;
    end else if (wr) begin
      if (op_data.size() == 0) res_valid = 0;
      op_data.push_back(data_in);
      op_attr.push_back(attr_in);
      if (op_data.size() == 3) begin
        if (op_data[0] != 0) begin
          res_data = op_data[1];
          res_attr = op_attr[1];
        end else begin
          res_data = op_data[2];
          res_attr = op_attr[2];
        end
        res_attr[0] = res_attr[0] | op_attr[0][0];
        res_valid = 1;
        op_data.delete();
        op_attr.delete();
      end
    end else if (oe && res_valid) begin
      res_valid = 0;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_attr;
    if (started) begin
      e_data = '0;
      e_attr = '0;
      if (oe) begin
        if (res_valid) begin
          e_data = res_data;
          e_attr = res_attr;
        end else begin
          e_attr = 4'b0001;
        end
      end
      chk("model_data_out", data_out, e_data);
      chk("model_attr_out", DW'(attr_out), DW'(e_attr));
      chk("model_busy", DW'(busy), DW'(op_data.size() != 0));
    end
  end

  task automatic step(input bit w, input bit o, input logic [DW-1:0] d, input logic [AW-1:0] a);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr = w;
    oe = o;
    data_in = d;
    attr_in = a;
  endtask

  task automatic expect_out(input string name, input logic [DW-1:0] d, input logic [AW-1:0] a);
    @(negedge clk);
    chk({name, "_data"}, data_out, d);
    chk({name, "_attr"}, DW'(attr_out), DW'(a));
  endtask

  initial begin
    // Reset
    @(posedge clk);
    #1;
    started = 1;
    @(negedge clk);
    chk("reset_busy", DW'(busy), 0);
    chk("reset_data", data_out, 0);
    chk("reset_attr", DW'(attr_out), 0);

    // 1: basic true select, then one-shot read
    step(1, 0, 1, 0); step(1, 0, 10, 0); step(1, 0, 20, 0);
    step(0, 1, 0, 0); expect_out("t1_read", 10, 4'b0000);
    step(0, 1, 0, 0); expect_out("t1_reread", 0, 4'b0001);

    // 2: false select, then nonzero non-one condition
    step(1, 0, 0, 0); step(1, 0, 32'hFFFF_FFFB, 0); step(1, 0, 32'h7FFF_FFFF, 0);
    step(0, 1, 0, 0); expect_out("t2_false", 32'h7FFF_FFFF, 4'b0000);
    step(1, 0, 32'hFFFF_0000, 0); step(1, 0, 3, 0); step(1, 0, 4, 0);
    step(0, 1, 0, 0); expect_out("t2_wide_true", 3, 4'b0000);

    // 3: invalid bit of cond merges into result attributes
    step(1, 0, 0, 4'b0001); step(1, 0, 7, 0); step(1, 0, 8, 4'b0010);
    step(0, 1, 0, 0); expect_out("t3_inv", 8, 4'b0011);

    // 4: premature read in GOT_A
    step(1, 0, 1, 0); step(1, 0, 9, 0);
    step(0, 1, 0, 0); expect_out("t4_early", 0, 4'b0001);
    chk("t4_busy", DW'(busy), 1);
    step(1, 0, 2, 0);
    step(0, 1, 0, 0); expect_out("t4_read", 9, 4'b0000);

    // 5: read and new cond write in the same cycle
    step(1, 0, 1, 0); step(1, 0, 4, 0); step(1, 0, 5, 0);
    step(1, 1, 0, 0); expect_out("t5_overlap", 4, 4'b0000);
    step(1, 0, 1, 0); step(1, 0, 6, 0);
    step(0, 1, 0, 0); expect_out("t5_read", 6, 4'b0000);

    // 6: reset mid-sequence
    step(1, 0, 1, 0); step(1, 0, 2, 0);
    @(posedge clk); #1; rst = 1'b1; wr = 0; oe = 0;
    step(0, 0, 0, 0);
    @(negedge clk); chk("t6_busy", DW'(busy), 0);
    step(0, 1, 0, 0); expect_out("t6_invalid", 0, 4'b0001);
    step(1, 0, 1, 0); step(1, 0, 11, 0); step(1, 0, 12, 0);
    step(0, 1, 0, 0); expect_out("t6_read", 11, 4'b0000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom());
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 60) == 0);
      wr = ($urandom_range(0, 2) != 0);
      oe = ($urandom_range(0, 2) == 0);
      data_in = d;
      attr_in = AW'($urandom());
    end
    @(posedge clk);
    #1;
    rst = 0; wr = 0; oe = 0;
    @(negedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
